// File: rtl/kernel_mem_bridge_pkg.sv
// Shared types, default widths and helpers for the kernel global-memory bridge.
package kernel_mem_bridge_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} wr_state_t;

  localparam int DEF_ADDR_WIDTH       = 32;
  localparam int DEF_DATA_WIDTH       = 512;
  localparam int DEF_BURSTCOUNT_WIDTH = 5;
  localparam int BC_MAX_WIDTH         = 16;

  // Avalon treats a burstcount of zero as a single-word transfer.
  function automatic logic [BC_MAX_WIDTH-1:0] burst_words(input logic [BC_MAX_WIDTH-1:0] bc);
    return (bc == '0) ? BC_MAX_WIDTH'(1) : bc;
  endfunction

endpackage

// File: rtl/kernel_mem_rd_credit.sv
// Tracks read words requested downstream but not yet returned, and blocks
// new reads that would push the count past MAX_RD_PENDING.
module kernel_mem_rd_credit
  import kernel_mem_bridge_pkg::*;
#(
  parameter int BURSTCOUNT_WIDTH = DEF_BURSTCOUNT_WIDTH,
  parameter int MAX_RD_PENDING   = 64,
  parameter int CNT_WIDTH        = $clog2(MAX_RD_PENDING + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rd_req_i,
  input  logic [BURSTCOUNT_WIDTH-1:0] burstcount_i,
  input  logic                        rd_accept_i,
  input  logic                        rd_valid_i,
  output logic [CNT_WIDTH-1:0]        rd_pending_o,
  output logic                        rd_block_o
);

  localparam int SUM_WIDTH = CNT_WIDTH + 1;

  logic [BURSTCOUNT_WIDTH-1:0] words;
  logic [SUM_WIDTH-1:0]        sum;
  logic [CNT_WIDTH-1:0]        pending_q, pending_d;

  assign words      = BURSTCOUNT_WIDTH'(burst_words(BC_MAX_WIDTH'(burstcount_i)));
  assign sum        = SUM_WIDTH'(pending_q) + SUM_WIDTH'(words);
  assign rd_block_o = rd_req_i & (sum > SUM_WIDTH'(MAX_RD_PENDING));

  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path writes pending_d and no latch is inferred.
  always_comb begin
    pending_d = pending_q;
    if (rd_accept_i) pending_d = pending_d + CNT_WIDTH'(words);
    if (rd_valid_i)  pending_d = pending_d - CNT_WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign rd_pending_o = pending_q;

endmodule

// File: rtl/kernel_mem_wrack_bridge.sv
// BSP-side kernel memory responder: forwards reads/writes to an Avalon-MM channel
// without write responses, synthesises per-burst writeack, and limits reads in flight.
module kernel_mem_wrack_bridge
  import kernel_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int BURSTCOUNT_WIDTH = DEF_BURSTCOUNT_WIDTH,
  parameter int BYTEENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_RD_PENDING   = 64
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   k_read,
  input  logic                                   k_write,
  input  logic [ADDR_WIDTH-1:0]                  k_address,
  input  logic [BURSTCOUNT_WIDTH-1:0]            k_burstcount,
  input  logic [DATA_WIDTH-1:0]                  k_writedata,
  input  logic [BYTEENABLE_WIDTH-1:0]            k_byteenable,
  output logic                                   k_waitrequest,
  output logic [DATA_WIDTH-1:0]                  k_readdata,
  output logic                                   k_readdatavalid,
  output logic                                   k_writeack,
  output logic                                   m_read,
  output logic                                   m_write,
  output logic [ADDR_WIDTH-1:0]                  m_address,
  output logic [BURSTCOUNT_WIDTH-1:0]            m_burstcount,
  output logic [DATA_WIDTH-1:0]                  m_writedata,
  output logic [BYTEENABLE_WIDTH-1:0]            m_byteenable,
  input  logic                                   m_waitrequest,
  input  logic [DATA_WIDTH-1:0]                  m_readdata,
  input  logic                                   m_readdatavalid,
  output logic [$clog2(MAX_RD_PENDING+1)-1:0]    rd_pending,
  output logic [31:0]                            wr_burst_count
);

  localparam int CNT_WIDTH = $clog2(MAX_RD_PENDING + 1);

  wr_state_t                   state_q;
  logic [BURSTCOUNT_WIDTH-1:0] beats_left_q;
  logic [BURSTCOUNT_WIDTH-1:0] wr_words;
  logic                        k_writeack_q;
  logic [31:0]                 wr_burst_count_q;
  logic                        rd_block;
  logic                        rd_accept;
  logic                        wr_accept;

  assign m_address       = k_address;
  assign m_burstcount    = k_burstcount;
  assign m_writedata     = k_writedata;
  assign m_byteenable    = k_byteenable;
  assign k_readdata      = m_readdata;
  assign k_readdatavalid = m_readdatavalid;

  // Writes win over reads; reads also wait out any write burst in progress.
  assign m_write       = reset_n & k_write;
  assign m_read        = reset_n & k_read & ~k_write & ~rd_block & (state_q == IDLE);
  assign k_waitrequest = ~reset_n | m_waitrequest | (k_read & ~m_read & ~k_write);

  assign rd_accept = m_read  & ~m_waitrequest;
  assign wr_accept = m_write & ~m_waitrequest;
  assign wr_words  = BURSTCOUNT_WIDTH'(burst_words(BC_MAX_WIDTH'(k_burstcount)));

  kernel_mem_rd_credit #(
    .BURSTCOUNT_WIDTH (BURSTCOUNT_WIDTH),
    .MAX_RD_PENDING   (MAX_RD_PENDING),
    .CNT_WIDTH        (CNT_WIDTH)
  ) u_rd_credit (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_req_i     (k_read),
    .burstcount_i (k_burstcount),
    .rd_accept_i  (rd_accept),
    .rd_valid_i   (m_readdatavalid),
    .rd_pending_o (rd_pending),
    .rd_block_o   (rd_block)
  );

  // Burst length is latched on the first beat; later beats' burstcount is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      beats_left_q     <= '0;
      k_writeack_q     <= 1'b0;
      wr_burst_count_q <= '0;
    end else begin
      k_writeack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_accept) begin
            if (wr_words <= BURSTCOUNT_WIDTH'(1)) begin
              k_writeack_q     <= 1'b1;
              wr_burst_count_q <= wr_burst_count_q + 32'd1;
            end else begin
              beats_left_q <= wr_words - BURSTCOUNT_WIDTH'(1);
              state_q      <= BURST;
            end
          end
        end
        BURST: begin
          if (wr_accept) begin
            beats_left_q <= beats_left_q - BURSTCOUNT_WIDTH'(1);
            if (beats_left_q == BURSTCOUNT_WIDTH'(1)) begin
              k_writeack_q     <= 1'b1;
              wr_burst_count_q <= wr_burst_count_q + 32'd1;
              state_q          <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign k_writeack     = k_writeack_q;
  assign wr_burst_count = wr_burst_count_q;

endmodule

// File: tb/tb_kernel_mem_wrack_bridge.sv
// Directed self-checking bench for kernel_mem_wrack_bridge: writeack timing,
// read credit limiting, read/write arbitration and reset behaviour.
module tb_kernel_mem_wrack_bridge;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int BW   = 5;
  localparam int BEW  = DW / 8;
  localparam int MAXP = 64;
  localparam int CW   = $clog2(MAXP + 1);

  // Row layout: {k_write, k_read, m_waitrequest, m_readdatavalid, burstcount[4:0],
  //              expected {m_read, m_write, k_waitrequest, k_writeack}}
  localparam int BURST_ROWS = 11;
  localparam logic [12:0] BURST_VEC [BURST_ROWS] = '{
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 4'b0100},
    {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0110},
    {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0110},
    {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 4'b0110},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100},
    {1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 4'b0010},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100},
    {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0001},
    {1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 4'b1000},
    {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 4'b0000}
  };

  localparam int B2B_ROWS = 12;
  localparam logic [12:0] B2B_VEC [B2B_ROWS] = '{
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 4'b0100},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 4'b0101},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 4'b0101},
    {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0001},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 4'b0100},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 4'b0101},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 4'b0100},
    {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0001},
    {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000},
    {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0100},
    {1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0001}
  };

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           k_read = 1'b0;
  logic           k_write = 1'b0;
  logic [AW-1:0]  k_address = '0;
  logic [BW-1:0]  k_burstcount = '0;
  logic [DW-1:0]  k_writedata = '0;
  logic [BEW-1:0] k_byteenable = '0;
  logic           k_waitrequest;
  logic [DW-1:0]  k_readdata;
  logic           k_readdatavalid;
  logic           k_writeack;
  logic           m_read;
  logic           m_write;
  logic [AW-1:0]  m_address;
  logic [BW-1:0]  m_burstcount;
  logic [DW-1:0]  m_writedata;
  logic [BEW-1:0] m_byteenable;
  logic           m_waitrequest = 1'b0;
  logic [DW-1:0]  m_readdata = '0;
  logic           m_readdatavalid = 1'b0;
  logic [CW-1:0]  rd_pending;
  logic [31:0]    wr_burst_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_wbc = '0;

  always #5 clk = ~clk;

  kernel_mem_wrack_bridge #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .BURSTCOUNT_WIDTH (BW),
    .BYTEENABLE_WIDTH (BEW),
    .MAX_RD_PENDING   (MAXP)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .k_read          (k_read),
    .k_write         (k_write),
    .k_address       (k_address),
    .k_burstcount    (k_burstcount),
    .k_writedata     (k_writedata),
    .k_byteenable    (k_byteenable),
    .k_waitrequest   (k_waitrequest),
    .k_readdata      (k_readdata),
    .k_readdatavalid (k_readdatavalid),
    .k_writeack      (k_writeack),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_address       (m_address),
    .m_burstcount    (m_burstcount),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .rd_pending      (rd_pending),
    .wr_burst_count  (wr_burst_count)
  );

  // Apply one cycle of stimulus just after the rising edge; return at the falling edge.
  task automatic drive(input logic w, input logic r, input logic [BW-1:0] bc,
                       input logic mw, input logic rv);
    @(posedge clk);
    #1;
    k_write         = w;
    k_read          = r;
    k_burstcount    = bc;
    m_waitrequest   = mw;
    m_readdatavalid = rv;
    @(negedge clk);
  endtask

  task automatic test_reset();
    k_read = 1'b1; k_write = 1'b1; k_burstcount = 5'd1; m_waitrequest = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_read, m_write, k_waitrequest, k_writeack} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp %b", {m_read, m_write, k_waitrequest, k_writeack}, 4'b0010);
    end
    checks++;
    if (rd_pending !== CW'(0)) begin
      errors++;
      $display("FAIL reset_rd_pending got %0d exp 0", rd_pending);
    end
    checks++;
    if (wr_burst_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_wr_burst_count got %0d exp 0", wr_burst_count);
    end
    @(posedge clk);
    #1;
    k_read = 1'b0; k_write = 1'b0; k_burstcount = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    k_address    = 32'h1234_5678;
    k_writedata  = 64'hdead_beef_0bad_f00d;
    k_byteenable = 8'ha5;
    m_readdata   = 64'h0123_4567_89ab_cdef;
    drive(1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
    checks++;
    if ({m_address, m_burstcount, m_writedata, m_byteenable} !==
        {32'h1234_5678, 5'd1, 64'hdead_beef_0bad_f00d, 8'ha5}) begin
      errors++;
      $display("FAIL passthrough_req got %h/%0d/%h/%h", m_address, m_burstcount, m_writedata, m_byteenable);
    end
    checks++;
    if (k_readdata !== 64'h0123_4567_89ab_cdef || k_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL passthrough_rd got %h/%b exp 0123456789abcdef/0", k_readdata, k_readdatavalid);
    end
    checks++;
    if ({m_read, m_write, k_waitrequest, k_writeack} !== 4'b0100) begin
      errors++;
      $display("FAIL single_write_beat got %b exp 0100", {m_read, m_write, k_waitrequest, k_writeack});
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    exp_wbc = exp_wbc + 32'd1;
    checks++;
    if (k_writeack !== 1'b1 || wr_burst_count !== exp_wbc) begin
      errors++;
      $display("FAIL single_write_ack got ack=%b cnt=%0d exp ack=1 cnt=%0d", k_writeack, wr_burst_count, exp_wbc);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (k_writeack !== 1'b0) begin
      errors++;
      $display("FAIL single_write_pulse got %b exp 0", k_writeack);
    end
  endtask

  task automatic test_burst_write();
    logic [12:0] row;
    for (int i = 0; i < BURST_ROWS; i++) begin
      row = BURST_VEC[i];
      drive(row[12], row[11], row[8:4], row[10], row[9]);
      checks++;
      if ({m_read, m_write, k_waitrequest, k_writeack} !== row[3:0]) begin
        errors++;
        $display("FAIL burst_write row %0d got %b exp %b", i,
                 {m_read, m_write, k_waitrequest, k_writeack}, row[3:0]);
      end
    end
    exp_wbc = exp_wbc + 32'd1;
    checks++;
    if (wr_burst_count !== exp_wbc) begin
      errors++;
      $display("FAIL burst_write_count got %0d exp %0d", wr_burst_count, exp_wbc);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (rd_pending !== CW'(0)) begin
      errors++;
      $display("FAIL burst_idle_read_drain got %0d exp 0", rd_pending);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] row;
    for (int i = 0; i < B2B_ROWS; i++) begin
      row = B2B_VEC[i];
      drive(row[12], row[11], row[8:4], row[10], row[9]);
      checks++;
      if ({m_read, m_write, k_waitrequest, k_writeack} !== row[3:0]) begin
        errors++;
        $display("FAIL back_to_back row %0d got %b exp %b", i,
                 {m_read, m_write, k_waitrequest, k_writeack}, row[3:0]);
      end
    end
    exp_wbc = exp_wbc + 32'd6;
    checks++;
    if (wr_burst_count !== exp_wbc) begin
      errors++;
      $display("FAIL back_to_back_count got %0d exp %0d", wr_burst_count, exp_wbc);
    end
  endtask

  task automatic test_read_credit();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
      checks++;
      if ({m_read, k_waitrequest} !== 2'b10 || rd_pending !== CW'(16 * i)) begin
        errors++;
        $display("FAIL credit_fill %0d got rd=%b wait=%b pend=%0d exp rd=1 wait=0 pend=%0d",
                 i, m_read, k_waitrequest, rd_pending, 16 * i);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
      checks++;
      if ({m_read, k_waitrequest} !== 2'b01 || rd_pending !== CW'(64)) begin
        errors++;
        $display("FAIL credit_full %0d got rd=%b wait=%b pend=%0d exp rd=0 wait=1 pend=64",
                 i, m_read, k_waitrequest, rd_pending);
      end
    end
    m_readdata = 64'hcafe_f00d_5555_aaaa;
    // 64 + 16 exceeds the limit until sixteen words have returned.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 5'd16, 1'b0, 1'b1);
      checks++;
      if ({m_read, k_waitrequest} !== 2'b01 || rd_pending !== CW'(64 - i)) begin
        errors++;
        $display("FAIL credit_drain %0d got rd=%b wait=%b pend=%0d exp rd=0 wait=1 pend=%0d",
                 i, m_read, k_waitrequest, rd_pending, 64 - i);
      end
      if (i == 0) begin
        checks++;
        if (k_readdatavalid !== 1'b1 || k_readdata !== 64'hcafe_f00d_5555_aaaa) begin
          errors++;
          $display("FAIL credit_rdata got %b/%h exp 1/cafef00d5555aaaa", k_readdatavalid, k_readdata);
        end
      end
    end
    drive(1'b0, 1'b1, 5'd16, 1'b0, 1'b1);
    checks++;
    if ({m_read, k_waitrequest} !== 2'b10 || rd_pending !== CW'(48)) begin
      errors++;
      $display("FAIL credit_release got rd=%b wait=%b pend=%0d exp rd=1 wait=0 pend=48",
               m_read, k_waitrequest, rd_pending);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (rd_pending !== CW'(63)) begin
      errors++;
      $display("FAIL credit_after_release got %0d exp 63", rd_pending);
    end
  endtask

  task automatic test_simultaneous_rd_valid();
    for (int i = 0; i < 53; i++) drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
    checks++;
    if (m_read !== 1'b1 || rd_pending !== CW'(10)) begin
      errors++;
      $display("FAIL simul_setup got rd=%b pend=%0d exp rd=1 pend=10", m_read, rd_pending);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (rd_pending !== CW'(17)) begin
      errors++;
      $display("FAIL simul_rd_valid got %0d exp 17", rd_pending);
    end
    drive(1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (rd_pending !== CW'(18)) begin
      errors++;
      $display("FAIL zero_burstcount_read got %0d exp 18", rd_pending);
    end
    for (int i = 0; i < 18; i++) drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (rd_pending !== CW'(0)) begin
      errors++;
      $display("FAIL simul_drain got %0d exp 0", rd_pending);
    end
  endtask

  task automatic test_rw_conflict();
    drive(1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    checks++;
    if ({m_read, m_write, k_waitrequest, k_writeack} !== 4'b0100) begin
      errors++;
      $display("FAIL rw_conflict_write got %b exp 0100", {m_read, m_write, k_waitrequest, k_writeack});
    end
    drive(1'b0, 1'b1, 5'd1, 1'b1, 1'b0);
    checks++;
    if ({m_read, m_write, k_waitrequest, k_writeack} !== 4'b1011) begin
      errors++;
      $display("FAIL rw_conflict_stalled_read got %b exp 1011", {m_read, m_write, k_waitrequest, k_writeack});
    end
    drive(1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    checks++;
    if ({m_read, m_write, k_waitrequest, k_writeack} !== 4'b1000 || rd_pending !== CW'(0)) begin
      errors++;
      $display("FAIL rw_conflict_read got %b pend=%0d exp 1000 pend=0",
               {m_read, m_write, k_waitrequest, k_writeack}, rd_pending);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    exp_wbc = exp_wbc + 32'd1;
    checks++;
    if (rd_pending !== CW'(1) || wr_burst_count !== exp_wbc) begin
      errors++;
      $display("FAIL rw_conflict_counts got pend=%0d cnt=%0d exp pend=1 cnt=%0d",
               rd_pending, wr_burst_count, exp_wbc);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    drive(1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd8, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 5'd8, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({m_read, m_write, k_waitrequest, k_writeack} !== 4'b0010 ||
          rd_pending !== CW'(0) || wr_burst_count !== 32'd0) begin
        errors++;
        $display("FAIL reset_mid_burst %0d got %b pend=%0d cnt=%0d exp 0010 pend=0 cnt=0", i,
                 {m_read, m_write, k_waitrequest, k_writeack}, rd_pending, wr_burst_count);
      end
    end
    @(posedge clk);
    #1;
    k_write = 1'b0; k_read = 1'b0; k_burstcount = '0;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (k_writeack !== 1'b0) begin
      errors++;
      $display("FAIL reset_dropped_ack got %b exp 0", k_writeack);
    end
    drive(1'b1, 1'b0, 5'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (k_writeack !== 1'b1 || wr_burst_count !== 32'd1) begin
      errors++;
      $display("FAIL post_reset_write got ack=%b cnt=%0d exp ack=1 cnt=1", k_writeack, wr_burst_count);
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (k_writeack !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pulse got %b exp 0", k_writeack);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_write();
    test_back_to_back();
    test_read_credit();
    test_simultaneous_rd_valid();
    test_rw_conflict();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
